thiele_kcolour_solver: RTL and testbench

Autonomous K-colouring search controller. It is the parametrised successor of the 3-colour autonomous solver, generalised to COLOURS colours, with these additions:
- an internal K-colour propagation core;
- adjacency and per-node cost latched at start;
- a backtrack budget, an abort input and a status code.

It sits beside the µ-ledger fabric and charges every decision and every forced deduction to the hardware µ-ledger.

---
 rtl/thiele_kcolour_pkg.sv | 51 +++++
 rtl/thiele_kcolour_solver_core.sv | 46 ++++
 rtl/thiele_kcolour_solver.sv | 243 ++++++++++++++++++++++++
 tb/tb_thiele_kcolour_solver.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/thiele_kcolour_pkg.sv
// Shared types and mask helpers for the K-colour search controller.
// Mask helpers take masks zero-extended to MAX_COLOURS bits so one set of functions serves every COLOURS value.
package thiele_kcolour_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_INIT,
      ST_PROPAGATE,
      ST_APPLY,
      ST_ACCUM_CONFLICT,
      ST_EVALUATE,
      ST_DECIDE,
      ST_ADVANCE,
      ST_COMMIT,
      ST_BACKTRACK,
      ST_FINISHED
   } state_t;

   localparam logic [1:0] STATUS_SAT    = 2'd0;
   localparam logic [1:0] STATUS_UNSAT  = 2'd1;
   localparam logic [1:0] STATUS_BUDGET = 2'd2;
   localparam logic [1:0] STATUS_ABORT  = 2'd3;

   localparam int MAX_COLOURS = 8;
   typedef logic [MAX_COLOURS-1:0] wmask_t;

   function automatic logic is_single(input wmask_t m);
      return (m != '0) && ((m & (m - 8'd1)) == '0);
   endfunction

   function automatic logic [3:0] popcount(input wmask_t m);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < MAX_COLOURS; i++) n = n + {3'b000, m[i]};
      return n;
   endfunction

   function automatic wmask_t lowest_bit(input wmask_t m);
      return m & (~m + 8'd1);
   endfunction

   function automatic logic [2:0] mask_to_index(input wmask_t m);
      logic [2:0] idx;
      idx = '0;
      for (int i = MAX_COLOURS - 1; i >= 0; i--) begin
         if (m[i]) idx = 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/thiele_kcolour_solver_core.sv
// Combinational K-colour propagation: strips every singleton neighbour's colour from each node's mask.
// valid flags nodes whose mask shrinks; conflict flags any node left with no colour.
module kcolour_reasoning_core
   import thiele_kcolour_pkg::*;
#(
   parameter int NODES   = 9,
   parameter int COLOURS = 3
) (
   input  logic [NODES*COLOURS-1:0] masks,
   input  logic [NODES*NODES-1:0]   adjacency,
   output logic [NODES*COLOURS-1:0] forced,
   output logic [NODES-1:0]         valid,
   output logic                     conflict
);

   logic [NODES-1:0] single;

   always_comb begin
      single = '0;
      for (int i = 0; i < NODES; i++)
         single[i] = is_single(wmask_t'(masks[i*COLOURS +: COLOURS]));
   end

   always_comb begin
      logic [COLOURS-1:0] blocked;
      logic [COLOURS-1:0] own;
      forced   = '0;
      valid    = '0;
      conflict = 1'b0;
      blocked  = '0;
      own      = '0;
      for (int i = 0; i < NODES; i++) begin
         blocked = '0;
         // Either triangle of the matrix marks an edge, so asymmetric inputs still behave.
         for (int j = 0; j < NODES; j++) begin
            if (j != i && (adjacency[i*NODES+j] || adjacency[j*NODES+i]) && single[j])
               blocked = blocked | masks[j*COLOURS +: COLOURS];
         end
         own = masks[i*COLOURS +: COLOURS];
         forced[i*COLOURS +: COLOURS] = own & ~blocked;
         valid[i] = ((own & ~blocked) != own);
         if ((own & ~blocked) == '0) conflict = 1'b1;
      end
   end

endmodule

// File: rtl/thiele_kcolour_solver.sv
// Autonomous K-colouring search: propagate, decide on the tightest node, backtrack through a snapshot stack.
// Every decision and forced deduction is charged to the question/information ledger.
module thiele_kcolour_solver
   import thiele_kcolour_pkg::*;
#(
   parameter int NODES           = 9,
   parameter int COLOURS         = 3,
   parameter int MU_PRECISION    = 16,
   parameter int LOG2_K_Q16      = 103872,
   parameter int DECISION_COST   = 136,
   parameter int BACKTRACK_LIMIT = 255,
   localparam int CW = (COLOURS > 1) ? $clog2(COLOURS) : 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    abort,
   input  logic [NODES*NODES-1:0]  adjacency,
   input  logic [32*NODES-1:0]     node_cost,
   output logic                    busy,
   output logic                    done,
   output logic [1:0]              status,
   output logic [NODES*CW-1:0]     colouring,
   output logic [31:0]             mu_question_bits,
   output logic [31:0]             mu_information_q16,
   output logic [31:0]             mu_total_q16,
   output logic [7:0]              decision_depth,
   output logic [7:0]              backtrack_count
);

   localparam int          MW       = NODES * COLOURS;
   localparam int          DW       = $clog2(NODES);
   localparam logic [7:0]  BT_LIMIT = 8'(BACKTRACK_LIMIT);
   localparam logic [31:0] DEC_COST = 32'(DECISION_COST);
   localparam logic [31:0] LOG2K    = 32'(LOG2_K_Q16);

   state_t state, state_nxt;

   logic [NODES*NODES-1:0] adj_r;
   logic [32*NODES-1:0]    cost_r;
   logic [MW-1:0]          masks, forced, forced_r;
   logic [NODES-1:0]       valid, valid_r;
   logic                   conflict;

   logic [MW-1:0]          stk_masks [NODES];
   logic [DW-1:0]          stk_node  [NODES];
   logic [COLOURS-1:0]     stk_avail [NODES];
   logic [COLOURS-1:0]     stk_tried [NODES];

   logic [COLOURS-1:0]     colour, pick_mask, pick_colour, remaining, rem_colour;
   logic [DW-1:0]          pick_node, didx, didx_m1;
   logic [3:0]             best;
   logic                   all_single, abort_hit, led_en;
   logic [NODES*CW-1:0]    sat_colouring;
   logic [7:0]             depth, bt_count;
   logic [31:0]            q, info, total, charge_q, charge_n, led_q, led_i, q_nxt, i_nxt;

   kcolour_reasoning_core #(.NODES(NODES), .COLOURS(COLOURS)) u_core (
      .masks     (masks),
      .adjacency (adj_r),
      .forced    (forced),
      .valid     (valid),
      .conflict  (conflict)
   );

   assign didx    = depth[DW-1:0];
   assign didx_m1 = didx - 1'b1;

   always_comb begin
      wmask_t     m;
      logic [3:0] pc;
      m             = '0;
      pc            = '0;
      all_single    = 1'b1;
      best          = 4'hF;
      pick_node     = '0;
      sat_colouring = '0;
      for (int i = 0; i < NODES; i++) begin
         m  = wmask_t'(masks[i*COLOURS +: COLOURS]);
         pc = popcount(m);
         if (!is_single(m)) all_single = 1'b0;
         if (pc > 4'd1 && pc < best) begin
            best      = pc;
            pick_node = DW'(i);
         end
         sat_colouring[i*CW +: CW] = CW'(mask_to_index(m));
      end
      pick_mask   = masks[pick_node*COLOURS +: COLOURS];
      pick_colour = COLOURS'(lowest_bit(wmask_t'(pick_mask)));
      remaining   = stk_avail[didx] & ~stk_tried[didx];
      rem_colour  = COLOURS'(lowest_bit(wmask_t'(remaining)));
   end

   always_comb begin
      charge_q = '0;
      charge_n = '0;
      for (int i = 0; i < NODES; i++) begin
         if (valid_r[i]) begin
            charge_q = charge_q + cost_r[i*32 +: 32];
            charge_n = charge_n + 32'd1;
         end
      end
   end

   assign abort_hit = abort && (state != ST_IDLE) && (state != ST_FINISHED);

   always_comb begin
      led_en = 1'b0;
      led_q  = '0;
      led_i  = '0;
      if (!abort_hit) begin
         case (state)
            ST_APPLY, ST_ACCUM_CONFLICT: begin
               led_en = 1'b1;
               led_q  = charge_q;
               led_i  = charge_n << MU_PRECISION;
            end
            ST_COMMIT: begin
               led_en = 1'b1;
               led_q  = DEC_COST;
               led_i  = LOG2K;
            end
            default: ;
         endcase
      end
      q_nxt = q + led_q;
      i_nxt = info + led_i;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:           if (start) state_nxt = ST_INIT;
         ST_INIT:           state_nxt = ST_PROPAGATE;
         ST_PROPAGATE:      state_nxt = conflict ? ST_ACCUM_CONFLICT :
                                        (|valid) ? ST_APPLY : ST_EVALUATE;
         ST_APPLY:          state_nxt = ST_PROPAGATE;
         ST_ACCUM_CONFLICT: state_nxt = ST_BACKTRACK;
         ST_EVALUATE:       state_nxt = all_single ? ST_FINISHED : ST_DECIDE;
         ST_DECIDE:         state_nxt = ST_COMMIT;
         ST_COMMIT:         state_nxt = ST_PROPAGATE;
         ST_BACKTRACK:      state_nxt = (depth == 8'd0 || bt_count == BT_LIMIT) ? ST_FINISHED : ST_ADVANCE;
         ST_ADVANCE:        state_nxt = (remaining == '0) ? ST_BACKTRACK : ST_COMMIT;
         ST_FINISHED:       if (!start) state_nxt = ST_IDLE;
         default:           state_nxt = ST_IDLE;
      endcase
      if (abort_hit) state_nxt = ST_FINISHED;
   end

   always_comb begin
      busy = (state != ST_IDLE) && (state != ST_FINISHED);
      done = (state == ST_FINISHED);
   end

   // The stack is only read at depths previously written in this run, so it needs no reset.
   always_ff @(posedge clk) begin
      if (state == ST_DECIDE && !abort_hit) begin
         stk_node[didx]  <= pick_node;
         stk_avail[didx] <= pick_mask;
         stk_tried[didx] <= '0;
      end
      if (state == ST_COMMIT && !abort_hit) begin
         stk_masks[didx] <= masks;
         stk_tried[didx] <= stk_tried[didx] | colour;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         adj_r     <= '0;
         cost_r    <= '0;
         masks     <= '1;
         forced_r  <= '0;
         valid_r   <= '0;
         colour    <= '0;
         depth     <= '0;
         bt_count  <= '0;
         status    <= STATUS_SAT;
         colouring <= '0;
         q         <= '0;
         info      <= '0;
         total     <= '0;
      end else if (abort_hit) begin
         status <= STATUS_ABORT;
      end else begin
         if (led_en) begin
            q     <= q_nxt;
            info  <= i_nxt;
            total <= (q_nxt << MU_PRECISION) + i_nxt;
         end
         case (state)
            ST_IDLE: if (start) begin
               adj_r    <= adjacency;
               cost_r   <= node_cost;
               masks    <= '1;
               depth    <= '0;
               bt_count <= '0;
               status   <= STATUS_SAT;
               q        <= '0;
               info     <= '0;
               total    <= '0;
            end
            ST_PROPAGATE: begin
               forced_r <= forced;
               valid_r  <= valid;
            end
            ST_APPLY:    masks <= forced_r;
            ST_EVALUATE: if (all_single) begin
               colouring <= sat_colouring;
               status    <= STATUS_SAT;
            end
            ST_DECIDE:   colour <= pick_colour;
            ST_COMMIT: begin
               masks[stk_node[didx]*COLOURS +: COLOURS] <= colour;
               depth <= depth + 8'd1;
            end
            ST_BACKTRACK: begin
               if (depth == 8'd0) status <= STATUS_UNSAT;
               else if (bt_count == BT_LIMIT) status <= STATUS_BUDGET;
               else begin
                  depth    <= depth - 8'd1;
                  bt_count <= bt_count + 8'd1;
                  masks    <= stk_masks[didx_m1];
               end
            end
            ST_ADVANCE:  if (remaining != '0) colour <= rem_colour;
            default: ;
         endcase
      end
   end

   assign mu_question_bits   = q;
   assign mu_information_q16 = info;
   assign mu_total_q16       = total;
   assign decision_depth     = depth;
   assign backtrack_count    = bt_count;

endmodule

// File: tb/tb_thiele_kcolour_solver.sv
// Directed bench: triangle, K4 (plain and zero budget), 2-colour even/odd rings, abort and mid-run reset.
module tb_thiele_kcolour_solver;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start_a = 1'b0, abort_a = 1'b0, start_n = 1'b0, abort_n = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [8:0]   adj_t;  logic [95:0]  cost_t;
   logic [15:0]  adj_k;  logic [127:0] cost_k;
   logic [15:0]  adj_p;  logic [127:0] cost_p;
   logic [24:0]  adj_o;  logic [159:0] cost_o;
   logic [80:0]  adj_n;  logic [287:0] cost_n;

   logic busy_t, done_t, busy_k, done_k, busy_b, done_b, busy_p, done_p, busy_o, done_o, busy_n, done_n;
   logic [1:0] st_t, st_k, st_b, st_p, st_o, st_n;
   logic [5:0] col_t; logic [7:0] col_k, col_b; logic [3:0] col_p; logic [4:0] col_o; logic [17:0] col_n;
   logic [31:0] q_t, i_t, tot_t, q_k, i_k, tot_k, q_b, i_b, tot_b, q_p, i_p, tot_p, q_o, i_o, tot_o, q_n, i_n, tot_n;
   logic [7:0] d_t, bt_t, d_k, bt_k, d_b, bt_b, d_p, bt_p, d_o, bt_o, d_n, bt_n;

   thiele_kcolour_solver #(.NODES(3), .COLOURS(3)) u_tri (
      .clk(clk), .reset(reset), .start(start_a), .abort(abort_a), .adjacency(adj_t), .node_cost(cost_t),
      .busy(busy_t), .done(done_t), .status(st_t), .colouring(col_t), .mu_question_bits(q_t),
      .mu_information_q16(i_t), .mu_total_q16(tot_t), .decision_depth(d_t), .backtrack_count(bt_t));

   thiele_kcolour_solver #(.NODES(4), .COLOURS(3)) u_k4 (
      .clk(clk), .reset(reset), .start(start_a), .abort(abort_a), .adjacency(adj_k), .node_cost(cost_k),
      .busy(busy_k), .done(done_k), .status(st_k), .colouring(col_k), .mu_question_bits(q_k),
      .mu_information_q16(i_k), .mu_total_q16(tot_k), .decision_depth(d_k), .backtrack_count(bt_k));

   thiele_kcolour_solver #(.NODES(4), .COLOURS(3), .BACKTRACK_LIMIT(0)) u_k4b (
      .clk(clk), .reset(reset), .start(start_a), .abort(abort_a), .adjacency(adj_k), .node_cost(cost_k),
      .busy(busy_b), .done(done_b), .status(st_b), .colouring(col_b), .mu_question_bits(q_b),
      .mu_information_q16(i_b), .mu_total_q16(tot_b), .decision_depth(d_b), .backtrack_count(bt_b));

   thiele_kcolour_solver #(.NODES(4), .COLOURS(2)) u_c4 (
      .clk(clk), .reset(reset), .start(start_a), .abort(abort_a), .adjacency(adj_p), .node_cost(cost_p),
      .busy(busy_p), .done(done_p), .status(st_p), .colouring(col_p), .mu_question_bits(q_p),
      .mu_information_q16(i_p), .mu_total_q16(tot_p), .decision_depth(d_p), .backtrack_count(bt_p));

   thiele_kcolour_solver #(.NODES(5), .COLOURS(2)) u_c5 (
      .clk(clk), .reset(reset), .start(start_a), .abort(abort_a), .adjacency(adj_o), .node_cost(cost_o),
      .busy(busy_o), .done(done_o), .status(st_o), .colouring(col_o), .mu_question_bits(q_o),
      .mu_information_q16(i_o), .mu_total_q16(tot_o), .decision_depth(d_o), .backtrack_count(bt_o));

   thiele_kcolour_solver #(.NODES(9), .COLOURS(3)) u_n9 (
      .clk(clk), .reset(reset), .start(start_n), .abort(abort_n), .adjacency(adj_n), .node_cost(cost_n),
      .busy(busy_n), .done(done_n), .status(st_n), .colouring(col_n), .mu_question_bits(q_n),
      .mu_information_q16(i_n), .mu_total_q16(tot_n), .decision_depth(d_n), .backtrack_count(bt_n));

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic wait_group_a();
      for (int c = 0; c < 4000 && !(done_t && done_k && done_b && done_p && done_o); c++) tick(1);
      chk("group_done_in_budget", {63'd0, done_t && done_k && done_b && done_p && done_o}, 64'd1);
   endtask

   initial begin
      adj_t  = 9'h0EE;     cost_t = {3{32'd136}};
      adj_k  = 16'h7BDE;   cost_k = {4{32'd5}};
      adj_p  = 16'h5A5A;   cost_p = {4{32'd1}};
      adj_o  = '0;         cost_o = {5{32'd1}};
      adj_n  = '0;         cost_n = {9{32'd7}};
      for (int i = 0; i < 5; i++) begin
         adj_o[i*5 + (i+1)%5] = 1'b1;
         adj_o[((i+1)%5)*5 + i] = 1'b1;
      end
      for (int i = 0; i < 9; i++) begin
         adj_n[i*9 + (i+1)%9] = 1'b1;
         adj_n[((i+1)%9)*9 + i] = 1'b1;
      end

      tick(2);
      chk("reset_busy", busy_t, 0);
      chk("reset_done", done_t, 0);
      chk("reset_status", st_t, 0);
      chk("reset_colouring", col_t, 0);
      chk("reset_question", q_t, 0);
      chk("reset_depth", d_t, 0);
      reset = 1'b0;
      tick(1);

      start_a = 1'b1;
      tick(1);
      chk("busy_after_start", busy_t, 1);
      chk("done_low_running", done_t, 0);
      wait_group_a();

      chk("tri_status", st_t, 0);
      chk("tri_colouring", col_t, 6'h24);
      chk("tri_depth", d_t, 2);
      chk("tri_backtracks", bt_t, 0);
      chk("tri_question", q_t, 680);
      chk("tri_information", i_t, 404352);
      chk("tri_total", tot_t, 44968832);
      chk("tri_busy_done", busy_t, 0);
      chk("k4_status", st_k, 1);
      chk("k4_depth", d_k, 0);
      chk("k4_backtracks", bt_k, 9);
      chk("k4b_status", st_b, 2);
      chk("k4b_backtracks", bt_b, 0);
      chk("k4b_depth", d_b, 2);
      chk("c4_status", st_p, 0);
      chk("c4_colouring", col_p, 4'b1010);
      chk("c5_status", st_o, 1);
      chk("c5_depth", d_o, 0);

      tick(3);
      chk("start_held_done", done_t, 1);
      chk("start_held_busy", busy_t, 0);
      start_a = 1'b0;
      tick(1);
      chk("idle_done_cleared", done_t, 0);
      tick(2);
      chk("idle_no_rerun", busy_t, 0);

      start_n = 1'b1;
      tick(1);
      chk("n9_busy", busy_n, 1);
      tick(4);
      abort_n = 1'b1;
      tick(1);
      chk("abort_done", done_n, 1);
      chk("abort_busy", busy_n, 0);
      chk("abort_status", st_n, 3);
      chk("abort_question_unchanged", q_n, 0);
      chk("abort_colouring_unchanged", col_n, 0);
      abort_n = 1'b0;
      start_n = 1'b0;
      tick(1);
      chk("abort_idle_done", done_n, 0);

      start_a = 1'b1;
      tick(7);
      chk("mid_question", q_t, 136);
      chk("mid_depth", d_t, 1);
      reset = 1'b1;
      #1;
      chk("rst_question", q_t, 0);
      chk("rst_depth", d_t, 0);
      chk("rst_busy", busy_t, 0);
      chk("rst_colouring", col_t, 0);
      chk("rst_total", tot_t, 0);
      tick(1);
      reset = 1'b0;
      wait_group_a();
      chk("rerun_status", st_t, 0);
      chk("rerun_colouring", col_t, 6'h24);
      chk("rerun_question", q_t, 680);
      chk("rerun_information", i_t, 404352);
      chk("rerun_k4_backtracks", bt_k, 9);
      start_a = 1'b0;
      tick(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
